// File: rtl/di_xfw_pkg.sv
// Shared types and constants for the cross-issue forwarding / hazard unit.
package di_xfw_pkg;

   localparam int unsigned ADDR_W        = 6;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned SEL_W         = 2;
   localparam int unsigned STALL_CNT_W   = 4;
   localparam int unsigned STALL_CNT_MAX = 15;

   // Operand source select as seen on fwd_sel_*_o
   typedef enum logic [SEL_W-1:0] {
      REGFILE = 2'd0,
      XFW_ALU = 2'd1,
      XFW_WB  = 2'd2
   } fwd_sel_t;

   // Load-use hazard FSM
   typedef enum logic {
      IDLE     = 1'b0,
      LU_STALL = 1'b1
   } state_t;

   // One write port of the other issue (enable, destination, data)
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } xfw_wr_t;

endpackage

// File: rtl/di_xfw_hazard_unit_opmux.sv
// Per-operand cross-issue forwarding mux (combinational).
//   i_raddr/i_rdata : operand address and own regfile read data
//   i_alu / i_wb    : other issue's EX (ALU) and WB write ports
//   o_operand_c     : selected operand data
//   o_sel_c         : selected source (ALU has priority over WB, x0 never forwarded)
module di_xfw_opmux
   import di_xfw_pkg::*;
(
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic [DATA_W-1:0] i_rdata,
   input  xfw_wr_t           i_alu,
   input  xfw_wr_t           i_wb,
   output logic [DATA_W-1:0] o_operand_c,
   output fwd_sel_t          o_sel_c
);

   logic w_nonzero;
   logic w_alu_hit;
   logic w_wb_hit;

   assign w_nonzero = (i_raddr != '0);
   assign w_alu_hit = w_nonzero && i_alu.we && (i_alu.waddr == i_raddr);
   assign w_wb_hit  = w_nonzero && i_wb.we  && (i_wb.waddr  == i_raddr);

   // Priority select: ALU result is younger than WB result
   always_comb begin
      o_operand_c = i_rdata;
      o_sel_c     = REGFILE;
      if (w_alu_hit) begin
         o_operand_c = i_alu.wdata;
         o_sel_c     = XFW_ALU;
      end else if (w_wb_hit) begin
         o_operand_c = i_wb.wdata;
         o_sel_c     = XFW_WB;
      end
   end

endmodule

// File: rtl/di_xfw_hazard_unit.sv
// Cross-issue forwarding and load-use hazard unit for one issue's ID stage.
// Forwards the other issue's EX/WB results into this issue's operands,
// stalls ID on a load-use dependency on the other issue's load, and
// registers the selected operands into the ID/EX boundary.
//   xfw_*            : other issue's write ports and EX load indication
//   id_valid_i       : ID holds a valid instruction
//   ex_ready_i       : EX can accept; 0 holds all registered outputs
//   raddr/use/rdata  : this issue's operands (A, B, C)
//   operand_*_o      : registered operands, fwd_sel_*_o registered sources
//   stall_o          : combinational stall to ID
//   valid_o          : registered operands valid for EX
//   stall_cnt_o      : saturating count of load-use stall cycles
// Build option: DI_XFW_OPC_EN enables forwarding/hazard checking on operand C.
module di_xfw_hazard_unit
   import di_xfw_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              xfw_regfile_we_wb,
   input  logic              xfw_regfile_alu_we_fw,
   input  logic [DATA_W-1:0] xfw_regfile_wdata_wb,
   input  logic [DATA_W-1:0] xfw_regfile_alu_wdata_fw,
   input  logic [ADDR_W-1:0] xfw_regfile_waddr_ex,
   input  logic [ADDR_W-1:0] xfw_regfile_waddr_wb,
   input  logic [ADDR_W-1:0] xfw_regfile_alu_waddr_fw,
   input  logic              xfw_load_ex,
   input  logic              id_valid_i,
   input  logic              ex_ready_i,
   input  logic [ADDR_W-1:0] raddr_a_i,
   input  logic [ADDR_W-1:0] raddr_b_i,
   input  logic [ADDR_W-1:0] raddr_c_i,
   input  logic              use_a_i,
   input  logic              use_b_i,
   input  logic              use_c_i,
   input  logic [DATA_W-1:0] rdata_a_i,
   input  logic [DATA_W-1:0] rdata_b_i,
   input  logic [DATA_W-1:0] rdata_c_i,
   output logic [DATA_W-1:0] operand_a_o,
   output logic [DATA_W-1:0] operand_b_o,
   output logic [DATA_W-1:0] operand_c_o,
   output logic [SEL_W-1:0]  fwd_sel_a_o,
   output logic [SEL_W-1:0]  fwd_sel_b_o,
   output logic [SEL_W-1:0]  fwd_sel_c_o,
   output logic              stall_o,
   output logic              valid_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   xfw_wr_t           w_alu;
   xfw_wr_t           w_wb;
   logic [DATA_W-1:0] w_op_a, w_op_b, w_op_c;
   fwd_sel_t          w_sel_a, w_sel_b, w_sel_c;
   logic              w_hit_a, w_hit_b, w_hit_c;
   logic              w_hazard;
   logic              w_release;
   logic              w_stall;
   logic              w_pend_ld;
   logic              w_load;
   state_t            w_state_nxt;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pend_addr;
   logic [DATA_W-1:0] r_op_a, r_op_b, r_op_c;
   fwd_sel_t          r_sel_a, r_sel_b, r_sel_c;
   logic              r_valid;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   assign w_alu = '{we: xfw_regfile_alu_we_fw, waddr: xfw_regfile_alu_waddr_fw,
                    wdata: xfw_regfile_alu_wdata_fw};
   assign w_wb  = '{we: xfw_regfile_we_wb, waddr: xfw_regfile_waddr_wb,
                    wdata: xfw_regfile_wdata_wb};

   di_xfw_opmux u_opmux_a (
      .i_raddr(raddr_a_i), .i_rdata(rdata_a_i), .i_alu(w_alu), .i_wb(w_wb),
      .o_operand_c(w_op_a), .o_sel_c(w_sel_a)
   );

   di_xfw_opmux u_opmux_b (
      .i_raddr(raddr_b_i), .i_rdata(rdata_b_i), .i_alu(w_alu), .i_wb(w_wb),
      .o_operand_c(w_op_b), .o_sel_c(w_sel_b)
   );

   assign w_hit_a = use_a_i && (raddr_a_i == xfw_regfile_waddr_ex);
   assign w_hit_b = use_b_i && (raddr_b_i == xfw_regfile_waddr_ex);

`ifdef DI_XFW_OPC_EN
   di_xfw_opmux u_opmux_c (
      .i_raddr(raddr_c_i), .i_rdata(rdata_c_i), .i_alu(w_alu), .i_wb(w_wb),
      .o_operand_c(w_op_c), .o_sel_c(w_sel_c)
   );
   assign w_hit_c = use_c_i && (raddr_c_i == xfw_regfile_waddr_ex);
`else
   // Operand C passes straight through from the regfile
   logic w_unused_c;
   assign w_unused_c = &{1'b0, raddr_c_i, use_c_i};
   assign w_op_c     = rdata_c_i;
   assign w_sel_c    = REGFILE;
   assign w_hit_c    = 1'b0;
`endif

   assign w_hazard  = id_valid_i && xfw_load_ex && (xfw_regfile_waddr_ex != '0) &&
                      (w_hit_a || w_hit_b || w_hit_c);
   assign w_release = xfw_regfile_we_wb && (xfw_regfile_waddr_wb == r_pend_addr);

   // Load-use FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Load-use FSM: next state and stall
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_pend_ld   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_hazard) begin
               w_stall     = 1'b1;
               w_pend_ld   = 1'b1;
               w_state_nxt = LU_STALL;
            end
         end
         LU_STALL: begin
            if (!id_valid_i || w_release) begin
               w_state_nxt = IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Reset must kill the stall at once, even with a hazard still on the inputs
   assign stall_o = w_stall && rst_n;
   assign w_load  = id_valid_i && ex_ready_i && !stall_o;

   // Pending load destination
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_addr <= '0;
      end else if (w_pend_ld) begin
         r_pend_addr <= xfw_regfile_waddr_ex;
      end
   end

   // ID/EX operand registers; ex_ready_i low freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_op_c  <= '0;
         r_sel_a <= REGFILE;
         r_sel_b <= REGFILE;
         r_sel_c <= REGFILE;
         r_valid <= 1'b0;
      end else if (ex_ready_i) begin
         r_valid <= w_load;
         if (w_load) begin
            r_op_a  <= w_op_a;
            r_op_b  <= w_op_b;
            r_op_c  <= w_op_c;
            r_sel_a <= w_sel_a;
            r_sel_b <= w_sel_b;
            r_sel_c <= w_sel_c;
         end
      end
   end

   // Saturating stall-cycle counter, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stall_o && (r_stall_cnt != STALL_CNT_W'(STALL_CNT_MAX))) begin
         r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
   end

   assign operand_a_o = r_op_a;
   assign operand_b_o = r_op_b;
   assign operand_c_o = r_op_c;
   assign fwd_sel_a_o = r_sel_a;
   assign fwd_sel_b_o = r_sel_b;
   assign fwd_sel_c_o = r_sel_c;
   assign valid_o     = r_valid;
   assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_di_xfw_hazard_unit.sv
// Self-checking bench for di_xfw_hazard_unit: directed scenarios followed by
// randomized traffic against a behavioural model.
module tb_di_xfw_hazard_unit;

   logic        clk;
   logic        rst_n;
   logic        xfw_regfile_we_wb, xfw_regfile_alu_we_fw;
   logic [31:0] xfw_regfile_wdata_wb, xfw_regfile_alu_wdata_fw;
   logic [5:0]  xfw_regfile_waddr_ex, xfw_regfile_waddr_wb, xfw_regfile_alu_waddr_fw;
   logic        xfw_load_ex, id_valid_i, ex_ready_i;
   logic [5:0]  raddr_a_i, raddr_b_i, raddr_c_i;
   logic        use_a_i, use_b_i, use_c_i;
   logic [31:0] rdata_a_i, rdata_b_i, rdata_c_i;
   logic [31:0] operand_a_o, operand_b_o, operand_c_o;
   logic [1:0]  fwd_sel_a_o, fwd_sel_b_o, fwd_sel_c_o;
   logic        stall_o, valid_o;
   logic [3:0]  stall_cnt_o;

   int checks = 0;
   int errors = 0;

   di_xfw_hazard_unit dut (
      .clk(clk), .rst_n(rst_n),
      .xfw_regfile_we_wb(xfw_regfile_we_wb), .xfw_regfile_alu_we_fw(xfw_regfile_alu_we_fw),
      .xfw_regfile_wdata_wb(xfw_regfile_wdata_wb), .xfw_regfile_alu_wdata_fw(xfw_regfile_alu_wdata_fw),
      .xfw_regfile_waddr_ex(xfw_regfile_waddr_ex), .xfw_regfile_waddr_wb(xfw_regfile_waddr_wb),
      .xfw_regfile_alu_waddr_fw(xfw_regfile_alu_waddr_fw), .xfw_load_ex(xfw_load_ex),
      .id_valid_i(id_valid_i), .ex_ready_i(ex_ready_i),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
      .use_a_i(use_a_i), .use_b_i(use_b_i), .use_c_i(use_c_i),
      .rdata_a_i(rdata_a_i), .rdata_b_i(rdata_b_i), .rdata_c_i(rdata_c_i),
      .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .operand_c_o(operand_c_o),
      .fwd_sel_a_o(fwd_sel_a_o), .fwd_sel_b_o(fwd_sel_b_o), .fwd_sel_c_o(fwd_sel_c_o),
      .stall_o(stall_o), .valid_o(valid_o), .stall_cnt_o(stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      xfw_regfile_we_wb = 0; xfw_regfile_alu_we_fw = 0;
      xfw_regfile_wdata_wb = 0; xfw_regfile_alu_wdata_fw = 0;
      xfw_regfile_waddr_ex = 0; xfw_regfile_waddr_wb = 0; xfw_regfile_alu_waddr_fw = 0;
      xfw_load_ex = 0;
      raddr_a_i = 0; raddr_b_i = 0; raddr_c_i = 0;
      use_a_i = 0; use_b_i = 0; use_c_i = 0;
      rdata_a_i = 0; rdata_b_i = 0; rdata_c_i = 0;
   endtask

   // ---------------- behavioural reference model ----------------
   logic        m_stalled;
   logic [5:0]  m_pend;
   int          m_cnt;
   logic [31:0] m_op [3];
   int          m_sel [3];
   logic        m_valid;

   // Source of one operand: {select, data}
   function automatic logic [33:0] ref_fwd(input logic [5:0] ra, input logic [31:0] rd);
      if (ra != 0 && xfw_regfile_alu_we_fw && xfw_regfile_alu_waddr_fw == ra)
         return {2'd1, xfw_regfile_alu_wdata_fw};
      if (ra != 0 && xfw_regfile_we_wb && xfw_regfile_waddr_wb == ra)
         return {2'd2, xfw_regfile_wdata_wb};
      return {2'd0, rd};
   endfunction

   function automatic logic ref_hazard();
      logic dep;
      dep = (use_a_i && raddr_a_i == xfw_regfile_waddr_ex) ||
            (use_b_i && raddr_b_i == xfw_regfile_waddr_ex);
`ifdef DI_XFW_OPC_EN
      dep = dep || (use_c_i && raddr_c_i == xfw_regfile_waddr_ex);
`endif
      return id_valid_i && xfw_load_ex && xfw_regfile_waddr_ex != 0 && dep;
   endfunction

   function automatic logic ref_stall();
      if (m_stalled)
         return id_valid_i && !(xfw_regfile_we_wb && xfw_regfile_waddr_wb == m_pend);
      return ref_hazard();
   endfunction

   function automatic logic [5:0] pick_addr();
      logic [5:0] tbl [4];
      tbl[0] = 6'd0; tbl[1] = 6'd5; tbl[2] = 6'd7; tbl[3] = 6'd33;
      return tbl[$urandom_range(0, 3)];
   endfunction

   logic [33:0] f;
   logic        exp_stall;
   logic [31:0] exp_c;
   int          exp_sel_c;

   initial begin
      clr();
      id_valid_i = 0; ex_ready_i = 0;
      rst_n = 0;
      #12;
      // Reset state
      chk("rst_op_a", operand_a_o, 0);
      chk("rst_op_c", operand_c_o, 0);
      chk("rst_sel_a", 32'(fwd_sel_a_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_cnt", 32'(stall_cnt_o), 0);
      chk("rst_stall", 32'(stall_o), 0);
      @(posedge clk); #1 rst_n = 1;

      // ALU forward wins over WB forward
      id_valid_i = 1; ex_ready_i = 1;
      raddr_a_i = 5; use_a_i = 1; rdata_a_i = 32'hAAAA;
      xfw_regfile_alu_we_fw = 1; xfw_regfile_alu_waddr_fw = 5; xfw_regfile_alu_wdata_fw = 32'h11;
      xfw_regfile_we_wb = 1; xfw_regfile_waddr_wb = 5; xfw_regfile_wdata_wb = 32'h22;
      raddr_c_i = 5; use_c_i = 1; rdata_c_i = 32'h3333;
      tick();
      chk("alu_op_a", operand_a_o, 32'h11);
      chk("alu_sel_a", 32'(fwd_sel_a_o), 1);
      chk("alu_valid", 32'(valid_o), 1);
`ifdef DI_XFW_OPC_EN
      chk("alu_op_c", operand_c_o, 32'h11);
      chk("alu_sel_c", 32'(fwd_sel_c_o), 1);
`else
      chk("alu_op_c", operand_c_o, 32'h3333);
      chk("alu_sel_c", 32'(fwd_sel_c_o), 0);
`endif

      // x0 is never forwarded
      clr();
      raddr_b_i = 0; use_b_i = 1; rdata_b_i = 32'h1234;
      xfw_regfile_alu_we_fw = 1; xfw_regfile_alu_waddr_fw = 0; xfw_regfile_alu_wdata_fw = 32'hFF;
      tick();
      chk("x0_op_b", operand_b_o, 32'h1234);
      chk("x0_sel_b", 32'(fwd_sel_b_o), 0);

      // FP register forwards from WB
      clr();
      raddr_a_i = 33; use_a_i = 1; rdata_a_i = 32'h9;
      xfw_regfile_we_wb = 1; xfw_regfile_waddr_wb = 33; xfw_regfile_wdata_wb = 32'h55;
      tick();
      chk("fp_op_a", operand_a_o, 32'h55);
      chk("fp_sel_a", 32'(fwd_sel_a_o), 2);

      // Load-use stall and release
      clr();
      raddr_a_i = 7; use_a_i = 1; rdata_a_i = 32'h77;
      xfw_load_ex = 1; xfw_regfile_waddr_ex = 7;
      #1 chk("lu_stall0", 32'(stall_o), 1);
      tick();
      chk("lu_valid", 32'(valid_o), 0);
      xfw_load_ex = 0;
      #1 chk("lu_stall1", 32'(stall_o), 1);
      tick();
      xfw_regfile_we_wb = 1; xfw_regfile_waddr_wb = 7; xfw_regfile_wdata_wb = 32'hCAFE;
      #1 chk("lu_rel_stall", 32'(stall_o), 0);
      chk("lu_rel_cnt", 32'(stall_cnt_o), 2);
      tick();
      chk("lu_rel_op_a", operand_a_o, 32'hCAFE);
      chk("lu_rel_sel_a", 32'(fwd_sel_a_o), 2);
      chk("lu_rel_valid", 32'(valid_o), 1);

      // Flush out of LU_STALL
      xfw_regfile_we_wb = 0;
      xfw_load_ex = 1;
      #1 chk("fl_stall0", 32'(stall_o), 1);
      tick();
      xfw_load_ex = 0; id_valid_i = 0;
      #1 chk("fl_stall_flush", 32'(stall_o), 0);
      tick();
      id_valid_i = 1;
      #1 chk("fl_idle", 32'(stall_o), 0);
      chk("fl_cnt", 32'(stall_cnt_o), 3);

      // Saturation, then reset mid-stall
      xfw_load_ex = 1;
      tick();
      xfw_load_ex = 0;
      for (int i = 0; i < 19; i++) tick();
      chk("sat_cnt", 32'(stall_cnt_o), 15);
      chk("sat_stall", 32'(stall_o), 1);
      rst_n = 0;
      #1;
      chk("rs_stall", 32'(stall_o), 0);
      chk("rs_cnt", 32'(stall_cnt_o), 0);
      chk("rs_op_a", operand_a_o, 0);
      chk("rs_sel_a", 32'(fwd_sel_a_o), 0);
      chk("rs_valid", 32'(valid_o), 0);
      tick();
      rst_n = 1;

      // Backpressure holds, release with no valid drops valid_o
      clr();
      raddr_a_i = 3; use_a_i = 1; rdata_a_i = 32'hBEEF;
      tick();
      chk("bp_load", operand_a_o, 32'hBEEF);
      ex_ready_i = 0; rdata_a_i = 32'hDEAD;
      xfw_regfile_alu_we_fw = 1; xfw_regfile_alu_waddr_fw = 3; xfw_regfile_alu_wdata_fw = 32'h1;
      tick();
      chk("bp_hold_op", operand_a_o, 32'hBEEF);
      chk("bp_hold_sel", 32'(fwd_sel_a_o), 0);
      chk("bp_hold_valid", 32'(valid_o), 1);
      ex_ready_i = 1; id_valid_i = 0;
      tick();
      chk("bp_rel_valid", 32'(valid_o), 0);
      chk("bp_rel_op", operand_a_o, 32'hBEEF);

      // Randomized traffic against the model, from a fresh reset
      rst_n = 0; clr(); id_valid_i = 0; ex_ready_i = 0;
      tick();
      rst_n = 1;
      m_stalled = 0; m_pend = 0; m_cnt = 0; m_valid = 0;
      for (int k = 0; k < 3; k++) begin m_op[k] = 0; m_sel[k] = 0; end
      for (int n = 0; n < 400; n++) begin
         id_valid_i = ($urandom_range(0, 99) < 85);
         ex_ready_i = ($urandom_range(0, 99) < 80);
         xfw_load_ex = ($urandom_range(0, 99) < 30);
         xfw_regfile_we_wb = 1'($urandom_range(0, 1));
         xfw_regfile_alu_we_fw = 1'($urandom_range(0, 1));
         xfw_regfile_waddr_ex = pick_addr();
         xfw_regfile_waddr_wb = pick_addr();
         xfw_regfile_alu_waddr_fw = pick_addr();
         xfw_regfile_wdata_wb = $urandom;
         xfw_regfile_alu_wdata_fw = $urandom;
         raddr_a_i = pick_addr(); raddr_b_i = pick_addr(); raddr_c_i = pick_addr();
         use_a_i = 1'($urandom_range(0, 1));
         use_b_i = 1'($urandom_range(0, 1));
         use_c_i = 1'($urandom_range(0, 1));
         rdata_a_i = $urandom; rdata_b_i = $urandom; rdata_c_i = $urandom;
         #1;
         exp_stall = ref_stall();
         chk("rnd_stall", 32'(stall_o), 32'(exp_stall));
         // Model update for the coming edge
         if (!m_stalled && exp_stall) m_pend = xfw_regfile_waddr_ex;
         m_stalled = exp_stall;
         if (exp_stall && m_cnt < 15) m_cnt++;
         if (ex_ready_i) begin
            m_valid = id_valid_i && !exp_stall;
            if (m_valid) begin
               f = ref_fwd(raddr_a_i, rdata_a_i); m_sel[0] = int'(f[33:32]); m_op[0] = f[31:0];
               f = ref_fwd(raddr_b_i, rdata_b_i); m_sel[1] = int'(f[33:32]); m_op[1] = f[31:0];
`ifdef DI_XFW_OPC_EN
               f = ref_fwd(raddr_c_i, rdata_c_i);
               exp_c = f[31:0]; exp_sel_c = int'(f[33:32]);
`else
               exp_c = rdata_c_i; exp_sel_c = 0;
`endif
               m_op[2] = exp_c; m_sel[2] = exp_sel_c;
            end
         end
         tick();
         chk("rnd_valid", 32'(valid_o), 32'(m_valid));
         chk("rnd_op_a", operand_a_o, m_op[0]);
         chk("rnd_op_b", operand_b_o, m_op[1]);
         chk("rnd_op_c", operand_c_o, m_op[2]);
         chk("rnd_sel_a", 32'(fwd_sel_a_o), 32'(m_sel[0]));
         chk("rnd_sel_b", 32'(fwd_sel_b_o), 32'(m_sel[1]));
         chk("rnd_sel_c", 32'(fwd_sel_c_o), 32'(m_sel[2]));
         chk("rnd_cnt", 32'(stall_cnt_o), 32'(m_cnt));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
